glyph_rom_arbiter: RTL

GLYPH_ROM_ARBITER -- requirements
Module: glyph_rom_arbiter

---
 rtl/glyph_rom_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/glyph_rom_arbiter.sv
// rtl/glyph_rom_arbiter.sv - display/host arbiter in front of a one-cycle-latency glyph ROM
// Optional anti-starvation for the host port is enabled by defining GLYPH_ARB_FAIR_EN.
module glyph_rom_arbiter #(
  parameter int GLYPH_DEPTH  = 256,
  parameter int STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_req,
  input  logic [7:0]  disp_glyph,
  input  logic [3:0]  disp_row,
  input  logic [3:0]  disp_col,
  output logic        disp_valid,
  output logic [23:0] disp_pixel,
  input  logic        host_req,
  input  logic [16:0] host_addr,
  output logic        host_ready,
  output logic        host_rvalid,
  output logic        host_err,
  output logic [23:0] host_rdata,
  output logic [16:0] rom_addr,
  input  logic [23:0] rom_data
);

  typedef enum logic [1:0] {H_IDLE, H_WAIT, H_BUSY} host_state_t;

  localparam logic [17:0] DEPTH_EXT = 18'(GLYPH_DEPTH);

  host_state_t state, next_state;

  logic        tag1_valid, tag1_host;
  logic        tag2_valid, tag2_host;
  logic        err_pend;
  logic        host_in_range;
  logic        starved;
  logic        host_grant;
  logic        disp_grant;
  logic        err_start;
  logic        host_ret;
  logic [16:0] disp_addr;

  assign disp_addr     = {1'b0, disp_glyph, disp_row, disp_col};
  assign host_in_range = {1'b0, host_addr} < DEPTH_EXT;
  assign host_ret      = tag2_valid && tag2_host;

`ifdef GLYPH_ARB_FAIR_EN
  localparam logic [4:0] STARVE_LIM = 5'(STARVE_LIMIT);
  logic [4:0] starve_cnt;

  assign starved = (starve_cnt == STARVE_LIM);

  // Counts consecutive waiting cycles lost to the display; saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (host_grant) begin
      starve_cnt <= '0;
    end else if (state == H_WAIT && disp_req && !starved) begin
      starve_cnt <= starve_cnt + 5'd1;
    end
  end
`else
  assign starved = 1'b0;
`endif

  always_comb begin
    next_state = state;
    host_grant = (state == H_WAIT) && (!disp_req || starved);
    disp_grant = disp_req && !host_grant;
    // An out-of-range request is answered directly; err_pend blocks re-acceptance
    // during the cycle the host is still dropping its request.
    err_start  = (state == H_IDLE) && host_req && !host_in_range && !err_pend;
    case (state)
      H_IDLE: if (host_req && host_in_range && !err_pend) next_state = H_WAIT;
      H_WAIT: if (host_grant) next_state = H_BUSY;
      H_BUSY: if (host_ret) next_state = H_IDLE;
      default: next_state = H_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= H_IDLE;
      rom_addr    <= '0;
      tag1_valid  <= 1'b0;
      tag1_host   <= 1'b0;
      tag2_valid  <= 1'b0;
      tag2_host   <= 1'b0;
      err_pend    <= 1'b0;
      disp_valid  <= 1'b0;
      disp_pixel  <= '0;
      host_ready  <= 1'b0;
      host_rvalid <= 1'b0;
      host_err    <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state      <= next_state;
      host_ready <= host_grant || err_start;
      err_pend   <= err_start;

      if (disp_grant) begin
        rom_addr <= disp_addr;
      end else if (host_grant) begin
        rom_addr <= host_addr;
      end

      tag1_valid <= disp_grant || host_grant;
      tag1_host  <= host_grant;
      tag2_valid <= tag1_valid;
      tag2_host  <= tag1_host;

      disp_valid <= tag2_valid && !tag2_host;
      if (tag2_valid && !tag2_host) begin
        disp_pixel <= rom_data;
      end

      if (host_ret) begin
        host_rvalid <= 1'b1;
        host_err    <= 1'b0;
        host_rdata  <= rom_data;
      end else if (err_pend) begin
        host_rvalid <= 1'b1;
        host_err    <= 1'b1;
        host_rdata  <= '0;
      end else begin
        host_rvalid <= 1'b0;
        host_err    <= 1'b0;
      end
    end
  end

endmodule
